// File: rtl/fht_addr_seq.sv
// fht_addr_seq: address sequencer for the in-place FHT datapath.
// Issues one quadruple of bank read addresses per clock for a run-time
// selectable transform length. Each read is mirrored as a write PIPE_LAT
// cycles later into the opposite ping-pong bank set. The sequencer also
// supplies the coefficient ROM address and the stage flags.
module fht_addr_seq #(
    parameter int A_BIT    = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iSTART,
    input  logic [3:0]       iLOG2N,
    input  logic             iHOLD,
    output logic             oRDY,
    output logic             oDONE,
    output logic             oERR,
    output logic [3:0]       oSTAGE,
    output logic             oST_ZERO,
    output logic             oST_LAST,
    output logic             oSRC,
    output logic [A_BIT-1:0] oADDR_RD_0,
    output logic [A_BIT-1:0] oADDR_RD_1,
    output logic [A_BIT-1:0] oADDR_RD_2,
    output logic [A_BIT-1:0] oADDR_RD_3,
    output logic [A_BIT-1:0] oADDR_WR_0,
    output logic [A_BIT-1:0] oADDR_WR_1,
    output logic [A_BIT-1:0] oADDR_WR_2,
    output logic [A_BIT-1:0] oADDR_WR_3,
    output logic             oWE_A,
    output logic             oWE_B,
    output logic [A_BIT-1:0] oADDR_COEF
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [3:0]     MAX_LOG2N = 4'(A_BIT + 2);
    localparam logic [A_BIT:0] ONE_W     = 1;
    localparam logic [A_BIT-1:0] ONE_A   = 1;
    localparam logic [2:0]     DRAIN_END = 3'(PIPE_LAT - 1);

    state_t           state, state_nxt;
    logic [3:0]       log2n, log2n_nxt;
    logic [3:0]       stage, stage_nxt;
    logic [A_BIT-1:0] rd_cnt, rd_cnt_nxt;
    logic [2:0]       drain_cnt, drain_cnt_nxt;

    logic             legal;
    logic [A_BIT:0]   len_full;
    logic [A_BIT-1:0] last_cnt;
    logic             last_stage;
    logic [3:0]       shift;
    logic [A_BIT-1:0] half;
    logic [A_BIT-1:0] sector;
    logic [A_BIT-1:0] rd_addr [4];
    logic [A_BIT-1:0] coef;
    logic             rd_valid;

    logic [A_BIT-1:0] dl_addr [PIPE_LAT][4];
    logic [PIPE_LAT-1:0] dl_valid;
    logic             wr_valid;

    assign legal      = (iLOG2N >= 4'd3) && (iLOG2N <= MAX_LOG2N);
    assign len_full   = ONE_W << (log2n - 4'd2);
    assign last_cnt   = A_BIT'(len_full - 1'b1);
    assign last_stage = (stage == log2n - 4'd2);
    assign shift      = log2n - 4'd1 - stage;
    assign half       = ONE_A << (shift - 4'd1);
    assign sector     = rd_cnt >> shift;
    assign rd_valid   = (state == RUN);

    // State and counter registers; a frozen cycle keeps everything as is
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state     <= IDLE;
            log2n     <= '0;
            stage     <= '0;
            rd_cnt    <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            log2n     <= log2n_nxt;
            stage     <= stage_nxt;
            rd_cnt    <= rd_cnt_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    // Frame sequencing: read sweep, pipeline drain, next stage or finish
    always_comb begin
        state_nxt     = state;
        log2n_nxt     = log2n;
        stage_nxt     = stage;
        rd_cnt_nxt    = rd_cnt;
        drain_cnt_nxt = drain_cnt;
        if (!iHOLD) begin
            case (state)
                IDLE: begin
                    if (iSTART && legal) begin
                        state_nxt  = RUN;
                        log2n_nxt  = iLOG2N;
                        stage_nxt  = '0;
                        rd_cnt_nxt = '0;
                    end
                end
                RUN: begin
                    if (rd_cnt == last_cnt) begin
                        state_nxt     = DRAIN;
                        rd_cnt_nxt    = '0;
                        drain_cnt_nxt = '0;
                    end else begin
                        rd_cnt_nxt = rd_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_END) begin
                        drain_cnt_nxt = '0;
                        if (last_stage) begin
                            state_nxt = DONE;
                        end else begin
                            state_nxt = RUN;
                            stage_nxt = stage + 4'd1;
                        end
                    end else begin
                        drain_cnt_nxt = drain_cnt + 3'd1;
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                    stage_nxt = '0;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Read and coefficient addresses; butterfly partners differ by half a span
    always_comb begin
        for (int b = 0; b < 4; b++) rd_addr[b] = '0;
        coef = '0;
        if (state == RUN) begin
            rd_addr[0] = rd_cnt;
            rd_addr[2] = rd_cnt;
            if (stage == 4'd0) begin
                rd_addr[1] = rd_cnt;
                rd_addr[3] = rd_cnt;
            end else begin
                rd_addr[1] = rd_cnt ^ half;
                rd_addr[3] = rd_cnt ^ half;
                for (int i = 0; i < A_BIT; i++) coef[i] = sector[A_BIT-1-i];
            end
        end
    end

    // Write delay line; slots only take a new address when a valid read arrives
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            dl_valid <= '0;
            for (int i = 0; i < PIPE_LAT; i++)
                for (int b = 0; b < 4; b++) dl_addr[i][b] <= '0;
        end else if (!iHOLD) begin
            dl_valid[0] <= rd_valid;
            if (rd_valid)
                for (int b = 0; b < 4; b++) dl_addr[0][b] <= rd_addr[b];
            for (int i = 1; i < PIPE_LAT; i++) begin
                dl_valid[i] <= dl_valid[i-1];
                if (dl_valid[i-1])
                    for (int b = 0; b < 4; b++) dl_addr[i][b] <= dl_addr[i-1][b];
            end
        end
    end

    assign wr_valid   = dl_valid[PIPE_LAT-1];
    assign oRDY       = (state == IDLE);
    assign oDONE      = (state == DONE);
    assign oERR       = (state == IDLE) && iSTART && !iHOLD && !legal;
    assign oSTAGE     = stage;
    assign oST_ZERO   = (state != IDLE) && (stage == 4'd0);
    assign oST_LAST   = (state != IDLE) && last_stage;
    assign oSRC       = stage[0];
    assign oADDR_RD_0 = rd_addr[0];
    assign oADDR_RD_1 = rd_addr[1];
    assign oADDR_RD_2 = rd_addr[2];
    assign oADDR_RD_3 = rd_addr[3];
    assign oADDR_WR_0 = dl_addr[PIPE_LAT-1][0];
    assign oADDR_WR_1 = dl_addr[PIPE_LAT-1][1];
    assign oADDR_WR_2 = dl_addr[PIPE_LAT-1][2];
    assign oADDR_WR_3 = dl_addr[PIPE_LAT-1][3];
    assign oWE_B      = wr_valid && !oSRC && !iHOLD;
    assign oWE_A      = wr_valid && oSRC && !iHOLD;
    assign oADDR_COEF = coef;

endmodule
